// File: rtl/freq_meter_bcd.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clocks and publishes the count as packed BCD.
module freq_meter_bcd #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned DIGITS      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  sig_in,
  output logic [4*DIGITS-1:0]   freq_bcd,
  output logic                  overflow,
  output logic                  valid,
  output logic                  gate_active
);

  localparam int unsigned          CntW     = $clog2(GATE_CYCLES);
  localparam logic [CntW-1:0]      CntLast  = CntW'(GATE_CYCLES - 1);
  localparam logic [4*DIGITS-1:0]  AllNines = {DIGITS{4'h9}};

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 dly_q, dly_d;
  logic [CntW-1:0]      gate_cnt_q, gate_cnt_d;
  logic [4*DIGITS-1:0]  acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic [4*DIGITS-1:0]  freq_bcd_q, freq_bcd_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
  logic                 gate_active_q, gate_active_d;

  logic                 edge_det;
  logic                 terminal;
  logic [4*DIGITS-1:0]  acc_inc;
  logic                 inc_ovf;

  assign edge_det = sync2_q & ~dly_q;
  assign terminal = (gate_cnt_q == CntLast);

  // Native BCD ripple increment; at all-9s the value saturates and flags overflow.
  always_comb begin : p_bcd_inc
    logic carry;
    acc_inc = acc_q;
    inc_ovf = 1'b0;
    carry   = 1'b0;
    if (edge_det) begin
      if (acc_q == AllNines) begin
        inc_ovf = 1'b1;
      end else begin
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (acc_inc[4*i +: 4] == 4'd9) begin
              acc_inc[4*i +: 4] = 4'd0;
            end else begin
              acc_inc[4*i +: 4] = acc_inc[4*i +: 4] + 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    sync1_d       = sig_in;
    sync2_d       = sync1_q;
    dly_d         = sync2_q;
    gate_active_d = 1'b1;
    gate_cnt_d    = terminal ? '0 : gate_cnt_q + CntW'(1);
    valid_d       = terminal;
    freq_bcd_d    = freq_bcd_q;
    overflow_d    = overflow_q;
    acc_d         = acc_inc;
    sticky_d      = sticky_q | inc_ovf;
    // An edge seen on the terminal cycle still belongs to the closing window.
    if (terminal) begin
      freq_bcd_d = acc_inc;
      overflow_d = sticky_q | inc_ovf;
      acc_d      = '0;
      sticky_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      dly_q         <= 1'b0;
      gate_cnt_q    <= '0;
      acc_q         <= '0;
      sticky_q      <= 1'b0;
      freq_bcd_q    <= '0;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      gate_active_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dly_q         <= dly_d;
      gate_cnt_q    <= gate_cnt_d;
      acc_q         <= acc_d;
      sticky_q      <= sticky_d;
      freq_bcd_q    <= freq_bcd_d;
      overflow_q    <= overflow_d;
      valid_q       <= valid_d;
      gate_active_q <= gate_active_d;
    end
  end

  assign freq_bcd    = freq_bcd_q;
  assign overflow    = overflow_q;
  assign valid       = valid_q;
  assign gate_active = gate_active_q;

endmodule
